// File: rtl/cpu_bus_pkg.sv
// Purpose: shared FSM state codes and address-map constants for the core-to-memory bus master.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_bus_pkg;

    // Master FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    // Address region codes reported by the decoder
    localparam logic [1:0] REGION_ROM      = 2'd0;
    localparam logic [1:0] REGION_RAM      = 2'd1;
    localparam logic [1:0] REGION_UNMAPPED = 2'd2;

    // Address map: ROM is 0..ROM_LIMIT-1, RAM is RW_BASE..RW_LIMIT-1, the rest is unmapped
    localparam int ROM_LIMIT = 128;
    localparam int RW_BASE   = 128;
    localparam int RW_LIMIT  = 224;

endpackage

// File: rtl/bus_region_decode.sv
// Purpose: classifies a core address into ROM/RAM/unmapped and flags whether the access is allowed.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever the inputs are.
module bus_region_decode #(
    parameter int RW_BASE  = cpu_bus_pkg::RW_BASE,
    parameter int RW_LIMIT = cpu_bus_pkg::RW_LIMIT
) (
    input  logic [7:0] address,
    input  logic       write,
    output logic       legal,
    output logic [1:0] region
);
    import cpu_bus_pkg::*;

    // Compare in 9 bits so a limit of 256 (no unmapped hole) still works without wrap
    localparam logic [8:0] BASE_9  = 9'(RW_BASE);
    localparam logic [8:0] LIMIT_9 = 9'(RW_LIMIT);

    logic [8:0] addr_9;
    assign addr_9 = {1'b0, address};

    // Region lookup and access permission: ROM is read-only, unmapped space refuses everything
    always_comb begin
        region = REGION_UNMAPPED;
        legal  = 1'b0;
        if (addr_9 < BASE_9) begin
            region = REGION_ROM;
            legal  = ~write;
        end else if (addr_9 < LIMIT_9) begin
            region = REGION_RAM;
            legal  = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_master.sv
// Purpose: single-outstanding core request to synchronous memory bus master with region checking.
// Latency: response 1 cycle after acceptance for refused accesses, 2 for stores, 3 for loads.
// Backpressure: ready is high only when idle; no queueing, the core holds req until accepted.
module mem_bus_master #(
    parameter int RW_BASE  = cpu_bus_pkg::RW_BASE,
    parameter int RW_LIMIT = cpu_bus_pkg::RW_LIMIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       ready,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       resp_err,
    output logic [7:0] bus_address,
    output logic       bus_write,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata
);
    import cpu_bus_pkg::*;

    logic [1:0] state_q, state_d;
    logic       wr_q, wr_d;
    logic [7:0] bus_address_q, bus_address_d;
    logic [7:0] bus_wdata_q, bus_wdata_d;
    logic       resp_err_q, resp_err_d;
    logic [7:0] resp_rdata_q, resp_rdata_d;

    logic       dec_legal;
    logic [1:0] dec_region;
    logic       unused_region;

    // Classification is done on the live request so the decision is made at the acceptance edge
    bus_region_decode #(
        .RW_BASE  (RW_BASE),
        .RW_LIMIT (RW_LIMIT)
    ) u_decode (
        .address (req_addr),
        .write   (req_write),
        .legal   (dec_legal),
        .region  (dec_region)
    );

    // Region code is exported by the decoder for other consumers; this block only needs legal
    assign unused_region = ^dec_region;

    // Outputs decode from state so a reset assertion drops bus_write and resp_valid immediately
    assign ready       = (state_q == ST_IDLE);
    assign resp_valid  = (state_q == ST_RESP);
    assign bus_write   = (state_q == ST_ISSUE) && wr_q;
    assign bus_address = bus_address_q;
    assign bus_wdata   = bus_wdata_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;

    // Next-state and datapath: latch on acceptance, respond from RESP, always return to IDLE
    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        bus_address_d = bus_address_q;
        bus_wdata_d   = bus_wdata_q;
        resp_err_d    = resp_err_q;
        resp_rdata_d  = resp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (dec_legal) begin
                        // Legal access: capture the request and drive it onto the bus next cycle
                        state_d       = ST_ISSUE;
                        wr_d          = req_write;
                        bus_address_d = req_addr;
                        bus_wdata_d   = req_wdata;
                    end else begin
                        // Refused access: skip the bus entirely and leave bus outputs untouched
                        state_d      = ST_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 8'h00;
                    end
                end
            end
            ST_ISSUE: begin
                if (wr_q) begin
                    state_d      = ST_RESP;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 8'h00;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // Memory presents read data one cycle after it saw the address
                state_d      = ST_RESP;
                resp_err_d   = 1'b0;
                resp_rdata_d = bus_rdata;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_q          <= 1'b0;
            bus_address_q <= 8'h00;
            bus_wdata_q   <= 8'h00;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= 8'h00;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
            resp_err_q    <= resp_err_d;
            resp_rdata_q  <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Purpose: self-checking bench for mem_bus_master against an address-map/latency reference model.
// Latency: not applicable.
// Backpressure: core side waits on ready before each request.
module tb_mem_bus_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       ready;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_err;
    logic [7:0] bus_address;
    logic       bus_write;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    // Reference model: full 256-byte image, ROM contents from a fixed formula
    logic [7:0] ref_mem [0:255];

    // Environment memories: 96x8 synchronous RAM plus ROM
    logic [7:0] env_ram [0:95];

    always #5 clk = ~clk;

    mem_bus_master dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .ready       (ready),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .bus_address (bus_address),
        .bus_write   (bus_write),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata)
    );

    function automatic logic [7:0] rom_val(input logic [7:0] a);
        return a ^ 8'hC3;
    endfunction

    // Synchronous memory model: registered read data, write on bus_write into RAM only
    always @(posedge clk) begin
        if (bus_address >= 8'd128 && bus_address < 8'd224) begin
            bus_rdata <= env_ram[bus_address - 8'd128];
            if (bus_write) env_ram[bus_address - 8'd128] <= bus_wdata;
        end else if (bus_address < 8'd128) begin
            bus_rdata <= rom_val(bus_address);
        end else begin
            bus_rdata <= 8'h00;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", {31'd0, ready}, 32'd1);
    endtask

    // One complete transaction: issue, then watch 6 cycles of responses and bus activity
    task automatic do_txn(input string tag, input logic w, input logic [7:0] a, input logic [7:0] d);
        logic       exp_err;
        int         exp_lat;
        logic [7:0] exp_rdata;
        int         lat, rv_cnt, bw_cnt, rdy_busy;
        logic       got_err;
        logic [7:0] got_rdata, bw_addr, bw_data;
        lat = 0; rv_cnt = 0; bw_cnt = 0; rdy_busy = 0;
        got_err = 1'b0; got_rdata = 8'h00; bw_addr = 8'h00; bw_data = 8'h00;

        exp_err   = (a >= 8'd224) || (w && a < 8'd128);
        exp_lat   = exp_err ? 1 : (w ? 2 : 3);
        exp_rdata = (exp_err || w) ? 8'h00 : ((a < 8'd128) ? rom_val(a) : ref_mem[a]);
        if (!exp_err && w) ref_mem[a] = d;

        wait_ready();
        req = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; req_write = $urandom; req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                rv_cnt++;
                if (lat == 0) begin
                    lat = k; got_err = resp_err; got_rdata = resp_rdata;
                end
            end
            if (bus_write) begin
                bw_cnt++; bw_addr = bus_address; bw_data = bus_wdata;
            end
            if (ready && lat == 0) rdy_busy++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_pulses"}, rv_cnt, 1);
        check({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
        check({tag, "_rdata"}, {24'd0, got_rdata}, {24'd0, exp_rdata});
        check({tag, "_buswrites"}, bw_cnt, (!exp_err && w) ? 1 : 0);
        check({tag, "_ready_busy"}, rdy_busy, 0);
        check({tag, "_hold_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        check({tag, "_hold_rdata"}, {24'd0, resp_rdata}, {24'd0, exp_rdata});
        if (!exp_err && w) begin
            check({tag, "_bw_addr"}, {24'd0, bw_addr}, {24'd0, a});
            check({tag, "_bw_data"}, {24'd0, bw_data}, {24'd0, d});
        end
    endtask

    initial begin
        logic [7:0] a, d;
        logic [7:0] haddr [0:3];
        int acc, rvs, consec, both, cnt;
        logic prev_rv;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 96; i++) env_ram[i] = 8'h00;
        reset = 1'b1; req = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;

        // Reset values
        @(negedge clk); @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_bus_write", {31'd0, bus_write}, 32'd0);
        check("rst_bus_address", {24'd0, bus_address}, 32'd0);
        check("rst_bus_wdata", {24'd0, bus_wdata}, 32'd0);
        check("rst_resp_rdata", {24'd0, resp_rdata}, 32'd0);
        reset = 1'b0;

        // Store then load back through RAM
        do_txn("st90", 1'b1, 8'h90, 8'h5A);
        do_txn("ld90", 1'b0, 8'h90, 8'h00);

        // Refused accesses
        do_txn("st10", 1'b1, 8'h10, 8'hA7);
        do_txn("ldE0", 1'b0, 8'hE0, 8'h00);
        do_txn("ldFF", 1'b0, 8'hFF, 8'h00);

        // Boundary loads and stores
        do_txn("ld7F", 1'b0, 8'h7F, 8'h00);
        do_txn("st80", 1'b1, 8'h80, 8'h3C);
        do_txn("ld80", 1'b0, 8'h80, 8'h00);
        do_txn("stDF", 1'b1, 8'hDF, 8'hE1);
        do_txn("ldDF", 1'b0, 8'hDF, 8'h00);
        do_txn("ldE0b", 1'b0, 8'hE0, 8'h00);
        do_txn("st7F", 1'b1, 8'h7F, 8'h11);

        // Back-to-back stores with req held high
        wait_ready();
        acc = 0; rvs = 0; consec = 0; both = 0; prev_rv = 1'b0;
        a = 8'h80; d = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (resp_valid) begin
                rvs++;
                if (prev_rv) consec++;
            end
            prev_rv = resp_valid;
            if (ready && resp_valid) both++;
            if (ready) begin
                if (acc < 4) begin
                    a = 8'($urandom_range(128, 223)); d = 8'($urandom);
                    haddr[acc] = a; ref_mem[a] = d;
                end
                acc++;
                req = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
            end else begin
                req_addr = 8'($urandom); req_wdata = 8'($urandom);
            end
        end
        req = 1'b0;
        check("hold_accepts", acc, 4);
        check("hold_resps", rvs, 4);
        check("hold_consec_resp", consec, 0);
        check("hold_ready_in_resp", both, 0);
        for (int i = 0; i < 4; i++) do_txn("hold_ld", 1'b0, haddr[i], 8'h00);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            if (($urandom % 3) == 0) a = 8'($urandom_range(128, 223));
            do_txn("rand", 1'($urandom), a, 8'($urandom));
        end

        // Reset during load CAPTURE
        wait_ready();
        req = 1'b1; req_write = 1'b0; req_addr = 8'h90; req_wdata = 8'h00;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstc_ready", {31'd0, ready}, 32'd1);
        check("rstc_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rstc_resp_err", {31'd0, resp_err}, 32'd0);
        check("rstc_bus_write", {31'd0, bus_write}, 32'd0);
        check("rstc_bus_address", {24'd0, bus_address}, 32'd0);
        check("rstc_bus_wdata", {24'd0, bus_wdata}, 32'd0);
        check("rstc_resp_rdata", {24'd0, resp_rdata}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid || !ready) cnt++;
        end
        check("rstc_no_resp", cnt, 0);

        // Machine still functional after reset
        do_txn("post_rst_ld", 1'b0, 8'h7F, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter RW_BASE, default 128: first address of the read/write RAM window.
REQ-002 Parameter RW_LIMIT, default 224: first address past the RAM window; RW_LIMIT..255 is unmapped.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  core request; valid only while asserted.
REQ-006 req_write  input  1  1 = store, 0 = load; sampled with req.
REQ-007 req_addr  input  8  core byte address; sampled with req.
REQ-008 req_wdata  input  8  store data; sampled with req.
REQ-009 ready  output  1  high only in IDLE; a request is accepted on a rising edge where req && ready.
REQ-010 resp_valid  output  1  one-cycle pulse marking completion of the accepted request.
REQ-011 resp_rdata  output  8  load data, valid while resp_valid is high.
REQ-012 resp_err  output  1  qualifies resp_valid; access was refused.
REQ-013 bus_address  output  8  address to the memories.
REQ-014 bus_write  output  1  write strobe to the memories.
REQ-015 bus_wdata  output  8  write data to the memories.
REQ-016 bus_rdata  input  8  registered read data from the memories; valid one cycle after the address edge.

Function
REQ-017 States are IDLE, ISSUE, CAPTURE and RESP; the block holds one request at a time and does no queueing.
REQ-018 On acceptance, the block latches req_write, req_addr and req_wdata; later req changes do not affect the request in flight.
REQ-019 Classification at acceptance: a store to 0..RW_BASE-1 (ROM) or any access to RW_LIMIT..255 is an error; every other access is legal.
REQ-020 Error path: IDLE -> RESP with no bus activity; in RESP, resp_err=1 and resp_rdata=0x00.
REQ-021 Legal store: IDLE -> ISSUE -> RESP; in ISSUE, bus_write=1 for exactly one cycle with bus_address and bus_wdata set to the latched values.
REQ-022 Legal load: IDLE -> ISSUE -> CAPTURE -> RESP; bus_write=0 throughout; resp_rdata is registered from bus_rdata at the end of CAPTURE.
REQ-023 Latency, counted from the acceptance edge N: resp_valid is high during cycle N+1 on the error path, N+2 for a store, N+3 for a load.
REQ-024 bus_address holds the latched address from ISSUE through RESP and keeps its last value in IDLE; bus_wdata holds likewise; bus_write is 0 in every state except store-ISSUE.
REQ-025 RESP always returns to IDLE, so ready is low in RESP; the earliest next acceptance is the edge ending the first IDLE cycle after RESP.
REQ-026 resp_rdata and resp_err hold their values until the next RESP; resp_valid is never high for two consecutive cycles.
REQ-027 Address boundaries: 127 is ROM, 128 and 223 are RAM, 224 and 255 are unmapped; no address wraps.

Reset
REQ-028 Reset forces IDLE immediately; ready=1 after reset; resp_valid, resp_err and bus_write are 0; bus_address, bus_wdata and resp_rdata are 0x00.
REQ-029 Reset in any state abandons the request in flight with no response pulse; bus_write drops asynchronously, so no partial write is issued after reset asserts.

Structure
REQ-030 The shared package cpu_bus_pkg holds the state enumeration and the region constants ROM_LIMIT=128, RW_BASE=128 and RW_LIMIT=224.
REQ-031 The address classifier is one combinational sub-module, bus_region_decode (inputs address and write; outputs legal and region).

Verification
REQ-032 Store 0x5A to 0x90, then load 0x90 with bus_rdata modelled by a 96x8 synchronous RAM -> store resp_valid at N+2 with err=0; load resp_valid at N+3 with rdata=0x5A.
REQ-033 Store to 0x10 -> resp_valid at N+1 with err=1 and rdata=0x00; bus_write stays 0 for the whole transaction.
REQ-034 Load from 0xE0, then load from 0xFF -> both respond err=1 at N+1 with no bus_write activity.
REQ-035 Boundary loads at 0x7F, 0x80, 0xDF and 0xE0 -> first three err=0 with RAM/ROM model data; 0xE0 err=1.
REQ-036 Hold req high continuously over back-to-back stores -> accepted once per transaction, ready low from acceptance through RESP, each resp_valid exactly one cycle wide.
REQ-037 Assert reset during load CAPTURE -> immediate IDLE with ready=1, no resp_valid pulse, and all outputs at their reset values.
